cmp_window_stats: RTL

Sequential stage directly downstream of the 4-bit magnitude comparator (cmp_4bit). Accepts a stream of operand pairs over a valid/ready handshake and registers each pair's eq/lst/grt result. It accumulates per-outcome counts and the maximum |a-b| over a window of WIN samples, then holds a summary record until the consumer takes it. Used wherever comparator outcomes must be aggregated rather than observed one pair at a time.

---
 rtl/cmp_pkg.sv | 24 ++
 rtl/cmp_4bit.sv | 21 ++
 rtl/cmp_window_stats.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator window-statistics slice.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    typedef struct packed {
        logic grt;
        logic lst;
        logic eq;
    } cmp_res_t;

    // Widest operand abs_diff supports; narrower operands are zero-extended by the caller.
    localparam int DIFF_W = 16;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] x,
                                                   input logic [DIFF_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/cmp_4bit.sv
// Unsigned magnitude comparator; exactly one of eq/lst/grt is set.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of a and b.
module cmp_4bit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    always_comb begin
        res     = '0;
        res.eq  = (a == b);
        res.lst = (a <  b);
        res.grt = (a >  b);
    end

endmodule

// File: rtl/cmp_window_stats.sv
// Aggregates cmp_4bit outcomes and max |a-b| over WIN accepted pairs into a summary record.
// Latency: per-pair flags one cycle after accept; summary valid the cycle after the WIN-th accept.
// Backpressure: in_ready only in ACCUM; summary held in REPORT until out_ready.
module cmp_window_stats
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WIN   = 8,
    parameter int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    output logic             eq,
    output logic             lst,
    output logic             grt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lst_cnt,
    output logic [CNT_W-1:0] grt_cnt,
    output logic [WIDTH-1:0] max_diff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state, state_nxt;
    cmp_res_t         cur_res, res_q;
    logic [WIDTH-1:0] cur_diff;
    logic [7:0]       idx;
    logic             accept, load, last;

    cmp_4bit #(.WIDTH(WIDTH)) u_cmp (
        .a   (a),
        .b   (b),
        .res (cur_res)
    );

    assign cur_diff  = WIDTH'(abs_diff(DIFF_W'(a), DIFF_W'(b)));
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == REPORT);
    assign busy      = (state != IDLE);
    // A pair presented alongside clr is dropped, never counted.
    assign accept    = in_valid & in_ready & ~clr;
    assign last      = (idx == 8'(WIN - 1));

    assign eq  = res_q.eq;
    assign lst = res_q.lst;
    assign grt = res_q.grt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ACCUM;
                        load      = 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept && last) state_nxt = REPORT;
                end
                REPORT: begin
                    if (out_ready) begin
                        // start with the accept chains straight into the next window
                        if (start) begin
                            state_nxt = ACCUM;
                            load      = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            res_valid <= 1'b0;
            eq_cnt    <= '0;
            lst_cnt   <= '0;
            grt_cnt   <= '0;
            max_diff  <= '0;
            idx       <= '0;
        end else if (clr) begin
            res_q     <= '0;
            res_valid <= 1'b0;
            eq_cnt    <= '0;
            lst_cnt   <= '0;
            grt_cnt   <= '0;
            max_diff  <= '0;
            idx       <= '0;
        end else begin
            res_valid <= accept;
            if (load) begin
                eq_cnt   <= '0;
                lst_cnt  <= '0;
                grt_cnt  <= '0;
                max_diff <= '0;
                idx      <= '0;
            end else if (accept) begin
                res_q <= cur_res;
                if (cur_res.eq)  eq_cnt  <= eq_cnt  + CNT_W'(1);
                if (cur_res.lst) lst_cnt <= lst_cnt + CNT_W'(1);
                if (cur_res.grt) grt_cnt <= grt_cnt + CNT_W'(1);
                if (cur_diff > max_diff) max_diff <= cur_diff;
                idx <= idx + 8'd1;
            end
        end
    end

endmodule
